// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word/RAM types plus memory scheduler state encoding
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DREAD  = 2'd2,
      DWRITE = 2'd3
   } sched_state_t;

   function automatic logic is_data_grant(input sched_state_t s);
      return (s == DREAD) || (s == DWRITE);
   endfunction

endpackage

// File: rtl/memory_scheduler_if.sv
// rtl/memory_scheduler_if.sv - fetch, memory-stage and RAM signals shared through the scheduler
interface memory_scheduler_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport sched (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport fetch (
      output iREN, iaddr,
      input  iwait, iload
   );

   modport mem (
      output dREN, dWEN, daddr, dstore,
      input  dwait, dload
   );

   modport ram (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );

endinterface

// File: rtl/sched_starve_ctr.sv
// rtl/sched_starve_ctr.sv - saturating count of data grants issued while an instruction read waits
module sched_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] MAX = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins over increment so an IGRANT entry always restarts the window.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == MAX);

endmodule

// File: rtl/memory_scheduler.sv
// rtl/memory_scheduler.sv - single-port RAM arbiter for fetch and memory stages
// Optional starvation guard: MEMORY_SCHEDULER_STARVE_GUARD_EN.
module memory_scheduler
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               CLK,
   input  logic               nRST,
   memory_scheduler_if.sched  bus
);

   sched_state_t state_q;
   sched_state_t state_d;
   logic         starve_hit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = bus.iREN;
      bus.dwait    = bus.dREN | bus.dWEN;
      bus.iload    = '0;
      bus.dload    = '0;

      case (state_q)
         IDLE: begin
            if (bus.iREN && starve_hit) begin
               state_d = IGRANT;
            end else if (bus.dWEN) begin
               state_d = DWRITE;
            end else if (bus.dREN) begin
               state_d = DREAD;
            end else if (bus.iREN) begin
               state_d = IGRANT;
            end
         end

         IGRANT: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            if (!bus.iREN) begin
               state_d = IDLE;
            end else if (bus.ramstate == ACCESS) begin
               bus.iwait = 1'b0;
               bus.iload = bus.ramload;
               state_d   = IDLE;
            end else if (bus.ramstate == ERROR) begin
               state_d = IDLE;
            end
         end

         DREAD: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.daddr;
            if (!bus.dREN) begin
               state_d = IDLE;
            end else if (bus.ramstate == ACCESS) begin
               bus.dwait = 1'b0;
               bus.dload = bus.ramload;
               state_d   = IDLE;
            end else if (bus.ramstate == ERROR) begin
               state_d = IDLE;
            end
         end

         DWRITE: begin
            bus.ramWEN   = 1'b1;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (!bus.dWEN) begin
               state_d = IDLE;
            end else if (bus.ramstate == ACCESS) begin
               bus.dwait = 1'b0;
               state_d   = IDLE;
            end else if (bus.ramstate == ERROR) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef MEMORY_SCHEDULER_STARVE_GUARD_EN
   logic starve_inc;
   logic starve_clr;

   // Only grants decided in IDLE count; retries after ERROR count again as new grants.
   assign starve_inc = (state_q == IDLE) && is_data_grant(state_d) && bus.iREN;
   assign starve_clr = (state_q == IDLE) && ((state_d == IGRANT) || !bus.iREN);

   sched_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i  (CLK),
      .rst_ni (nRST),
      .inc_i  (starve_inc),
      .clr_i  (starve_clr),
      .hit_o  (starve_hit)
   );
`else
   logic unused_starve_limit;

   assign starve_hit          = 1'b0;
   assign unused_starve_limit = ^STARVE_LIMIT;
`endif

endmodule

// File: tb/tb_memory_scheduler.sv
// tb/tb_memory_scheduler.sv - scoreboard bench for memory_scheduler with a latency-programmable RAM model
module tb_memory_scheduler;
   import cpu_types_pkg::*;

   typedef struct packed {
      logic  wr;
      word_t addr;
      word_t data;
   } exp_t;

   logic CLK;
   logic nRST;

   memory_scheduler_if bus ();

   memory_scheduler #(
      .STARVE_LIMIT (4)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int checks = 0;
   int passes = 0;

   exp_t exp_i[$];
   exp_t exp_d[$];
   exp_t me;

   int lat = 0;
   int ram_cnt;
   int err_req = 0;
   int err_done = 0;

   word_t     mem     [0:255];
   logic      written [0:255];
   ramstate_t ram_st;
   word_t     ram_rd;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic word_t init_val(input word_t a);
      if (a[9:2] == 8'h10) return 32'h8C010004;
      return {24'hC0FFEE, a[9:2]};
   endfunction

   always_comb begin
      ram_st = FREE;
      if (bus.ramREN || bus.ramWEN) begin
         if (err_done < err_req) ram_st = ERROR;
         else if (ram_cnt >= lat) ram_st = ACCESS;
         else ram_st = BUSY;
      end
   end

   always_comb begin
      if (written[bus.ramaddr[9:2]] === 1'b1) ram_rd = mem[bus.ramaddr[9:2]];
      else ram_rd = init_val(bus.ramaddr);
   end

   assign bus.ramstate = ram_st;
   assign bus.ramload  = ram_rd;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) ram_cnt <= 0;
      else if ((bus.ramREN || bus.ramWEN) && ram_st == BUSY) ram_cnt <= ram_cnt + 1;
      else ram_cnt <= 0;
   end

   always @(posedge CLK) begin
      if (bus.ramWEN && ram_st == ACCESS) begin
         mem[bus.ramaddr[9:2]]     <= bus.ramstore;
         written[bus.ramaddr[9:2]] <= 1'b1;
      end
      if (ram_st == ERROR) err_done <= err_done + 1;
   end

   // Completion monitor: every wait-low cycle must match the oldest pushed expectation.
   always @(negedge CLK) begin
      if (bus.iREN && !bus.iwait) begin
         checks = checks + 1;
         if (exp_i.size() == 0) begin
            $display("FAIL icomp_unexpected: got addr %h expected no completion", bus.ramaddr);
         end else begin
            me = exp_i.pop_front();
            if ({bus.ramREN, bus.ramaddr, bus.iload} !== {1'b1, me.addr, me.data})
               $display("FAIL icomp: got ren=%b addr=%h iload=%h expected ren=1 addr=%h iload=%h",
                        bus.ramREN, bus.ramaddr, bus.iload, me.addr, me.data);
            else passes = passes + 1;
         end
      end
      if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
         checks = checks + 1;
         if (exp_d.size() == 0) begin
            $display("FAIL dcomp_unexpected: got addr %h expected no completion", bus.ramaddr);
         end else begin
            me = exp_d.pop_front();
            if (me.wr) begin
               if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore} !== {1'b1, 1'b0, me.addr, me.data})
                  $display("FAIL dwrite_comp: got wen=%b ren=%b addr=%h store=%h expected wen=1 ren=0 addr=%h store=%h",
                           bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, me.addr, me.data);
               else passes = passes + 1;
            end else begin
               if ({bus.ramREN, bus.ramaddr, bus.dload} !== {1'b1, me.addr, me.data})
                  $display("FAIL dread_comp: got ren=%b addr=%h dload=%h expected ren=1 addr=%h dload=%h",
                           bus.ramREN, bus.ramaddr, bus.dload, me.addr, me.data);
               else passes = passes + 1;
            end
         end
      end
   end

   task automatic wait_done(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (is_d ? !bus.dwait : !bus.iwait) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      bus.iREN = 1'b0; bus.iaddr = '0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
      lat = 0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.iload, bus.dwait, bus.dload} !== '0)
         $display("FAIL reset_outputs_zero: got ren=%b wen=%b addr=%h iwait=%b dwait=%b expected all 0",
                  bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.dwait);
      else passes++;
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN} !== {IDLE, 1'b0})
         $display("FAIL reset_hold: got state=%0d ren=%b expected state=0 ren=0", dut.state_q, bus.ramREN);
      else passes++;
      exp_i.push_back(exp_t'{1'b0, 32'h40, 32'h8C010004});
      @(posedge CLK); #1 nRST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b1, 32'h40, 1'b0, 32'h8C010004})
         $display("FAIL reset_first_grant: got ren=%b addr=%h iwait=%b iload=%h expected 1 00000040 0 8c010004",
                  bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
      else passes++;
      @(posedge CLK); #1 bus.iREN = 1'b0;
   endtask

   task automatic test_priority();
      bit ok;
      lat = 1;
      @(posedge CLK); #1;
      exp_d.push_back(exp_t'{1'b0, 32'h100, init_val(32'h100)});
      exp_i.push_back(exp_t'{1'b0, 32'h40, 32'h8C010004});
      bus.dREN = 1'b1; bus.daddr = 32'h100;
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait} !== {DREAD, 1'b1, 32'h100, 1'b1, 1'b1})
         $display("FAIL prio_dread_first: got state=%0d ren=%b addr=%h iwait=%b dwait=%b expected 2 1 00000100 1 1",
                  dut.state_q, bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait);
      else passes++;
      wait_done(1'b1, ok);
      checks++;
      if (!ok) $display("FAIL prio_dread_timeout: got no completion expected dwait low");
      else passes++;
      @(posedge CLK); #1 bus.dREN = 1'b0;
      @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN, bus.iwait} !== {IDLE, 1'b0, 1'b1})
         $display("FAIL prio_idle_gap: got state=%0d ren=%b iwait=%b expected 0 0 1", dut.state_q, bus.ramREN, bus.iwait);
      else passes++;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN, bus.ramaddr} !== {IGRANT, 1'b1, 32'h40})
         $display("FAIL prio_igrant: got state=%0d ren=%b addr=%h expected 1 1 00000040", dut.state_q, bus.ramREN, bus.ramaddr);
      else passes++;
      wait_done(1'b0, ok);
      checks++;
      if (!ok) $display("FAIL prio_igrant_timeout: got no completion expected iwait low");
      else passes++;
      @(posedge CLK); #1 bus.iREN = 1'b0;
   endtask

   task automatic test_write();
      bit ok;
      lat = 2;
      @(posedge CLK); #1;
      exp_d.push_back(exp_t'{1'b1, 32'h200, 32'hDEADBEEF});
      bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({bus.ramWEN, bus.ramREN, bus.ramstore, bus.dwait} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b1})
         $display("FAIL write_drive: got wen=%b ren=%b store=%h dwait=%b expected 1 0 deadbeef 1",
                  bus.ramWEN, bus.ramREN, bus.ramstore, bus.dwait);
      else passes++;
      wait_done(1'b1, ok);
      checks++;
      if (!ok) $display("FAIL write_timeout: got no completion expected dwait low");
      else passes++;
      @(posedge CLK); #1 bus.dWEN = 1'b0; bus.dREN = 1'b0;
      @(posedge CLK); #1;
      exp_d.push_back(exp_t'{1'b0, 32'h200, 32'hDEADBEEF});
      bus.dREN = 1'b1;
      wait_done(1'b1, ok);
      checks++;
      if (!ok) $display("FAIL readback_timeout: got no completion expected dwait low");
      else passes++;
      @(posedge CLK); #1 bus.dREN = 1'b0;
   endtask

   task automatic test_error();
      bit ok;
      lat = 0;
      @(posedge CLK); #1;
      err_req = err_req + 1;
      exp_i.push_back(exp_t'{1'b0, 32'h80, init_val(32'h80)});
      bus.iREN = 1'b1; bus.iaddr = 32'h80;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramstate, bus.iwait} !== {IGRANT, ERROR, 1'b1})
         $display("FAIL error_hold_wait: got state=%0d ramstate=%0d iwait=%b expected 1 3 1", dut.state_q, bus.ramstate, bus.iwait);
      else passes++;
      @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN, bus.iwait} !== {IDLE, 1'b0, 1'b1})
         $display("FAIL error_to_idle: got state=%0d ren=%b iwait=%b expected 0 0 1", dut.state_q, bus.ramREN, bus.iwait);
      else passes++;
      wait_done(1'b0, ok);
      checks++;
      if (!ok) $display("FAIL error_retry_timeout: got no completion expected iwait low");
      else passes++;
      @(posedge CLK); #1 bus.iREN = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      lat = 5;
      @(posedge CLK); #1;
      exp_d.push_back(exp_t'{1'b1, 32'h300, 32'h12345678});
      bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h12345678;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramWEN, bus.ramstate} !== {DWRITE, 1'b1, BUSY})
         $display("FAIL rmid_busy: got state=%0d wen=%b ramstate=%0d expected 3 1 1", dut.state_q, bus.ramWEN, bus.ramstate);
      else passes++;
      #2 nRST = 1'b0;
      #1;
      checks++;
      if ({bus.ramWEN, bus.dwait} !== {1'b0, 1'b1})
         $display("FAIL rmid_async_drop: got wen=%b dwait=%b expected 0 1", bus.ramWEN, bus.dwait);
      else passes++;
      @(posedge CLK); #1 nRST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({bus.ramWEN, bus.ramaddr} !== {1'b1, 32'h300})
         $display("FAIL rmid_regrant: got wen=%b addr=%h expected 1 00000300", bus.ramWEN, bus.ramaddr);
      else passes++;
      wait_done(1'b1, ok);
      checks++;
      if (!ok) $display("FAIL rmid_timeout: got no completion expected dwait low");
      else passes++;
      @(posedge CLK); #1 bus.dWEN = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      lat = 0;
      @(posedge CLK); #1;
      exp_i.push_back(exp_t'{1'b0, 32'h40, 32'h8C010004});
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      wait_done(1'b0, ok);
      checks++;
      if (!ok) $display("FAIL b2b_first_timeout: got no completion expected iwait low");
      else passes++;
      @(posedge CLK); #1;
      exp_i.push_back(exp_t'{1'b0, 32'h80, init_val(32'h80)});
      bus.iaddr = 32'h80;
      @(negedge CLK);
      checks++;
      if ({dut.state_q, bus.ramREN} !== {IDLE, 1'b0})
         $display("FAIL b2b_idle_gap: got state=%0d ren=%b expected 0 0", dut.state_q, bus.ramREN);
      else passes++;
      wait_done(1'b0, ok);
      checks++;
      if (!ok) $display("FAIL b2b_second_timeout: got no completion expected iwait low");
      else passes++;
      @(posedge CLK); #1 bus.iREN = 1'b0;
   endtask

   task automatic test_starve();
      string        seq;
      string        want;
      int           dn;
      sched_state_t prev;
      bit           ok;
      seq = ""; dn = 0; prev = IDLE; ok = 1'b0;
      lat = 0;
`ifdef MEMORY_SCHEDULER_STARVE_GUARD_EN
      want = "DDDDIDDDD";
      exp_i.push_back(exp_t'{1'b0, 32'h40, 32'h8C010004});
`else
      want = "DDDDDDDD";
`endif
      @(posedge CLK); #1;
      for (int k = 0; k < 8; k++) exp_d.push_back(exp_t'{1'b0, 32'h100, init_val(32'h100)});
      bus.dREN = 1'b1; bus.daddr = 32'h100;
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK);
         if (dut.state_q != prev && dut.state_q != IDLE) begin
            if (dut.state_q == IGRANT) seq = {seq, "I"};
            else seq = {seq, "D"};
         end
         prev = dut.state_q;
         if (bus.dREN && !bus.dwait) dn++;
         if (dn == 8) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge CLK); #1 bus.dREN = 1'b0; bus.iREN = 1'b0;
      checks++;
      if (!ok) $display("FAIL starve_timeout: got %0d data completions expected 8", dn);
      else passes++;
      checks++;
      if (seq != want) $display("FAIL starve_sequence: got %s expected %s", seq, want);
      else passes++;
   endtask

   task automatic test_drain();
      repeat (3) @(negedge CLK);
      checks++;
      if ({exp_i.size(), exp_d.size()} !== {32'd0, 32'd0})
         $display("FAIL scoreboard_drain: got i=%0d d=%0d pending expected 0 0", exp_i.size(), exp_d.size());
      else passes++;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_priority();
      test_write();
      test_error();
      test_reset_mid();
      test_back_to_back();
      test_starve();
      test_drain();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
